mux4_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one 4:1 multiplexer path (structuralMultiplexer / behavioralMultiplexer) between four requesters.
- Grants ownership to one requester at a time and drives the mux address lines (address1:address0) to the owner's index.
- Holds ownership until the owner releases, drops its request, or hits a hold limit.
- Sits between requester-side control logic and the mux datapath in the ALU/CPU.

---
 rtl/mux4_rr_arbiter_pkg.sv | 19 +
 rtl/mux4_rr_arbiter_if.sv | 23 ++
 rtl/mux4_rr_arbiter_rr_priority_pick.sv | 37 +++
 rtl/mux4_rr_arbiter.sv | 101 ++++++++++
 tb/tb_mux4_rr_arbiter.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/mux4_rr_arbiter_pkg.sv
// rtl/mux4_rr_arbiter_pkg.sv - shared constants, state encoding and helpers for the mux arbiter
package mux4_rr_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// rtl/mux4_rr_arbiter_if.sv - requester/arbiter handshake bundle for the shared 4:1 mux path
interface mux4_rr_arbiter_if;

    logic [mux4_rr_arbiter_pkg::NUM_REQ-1:0] req;
    // "release" is a reserved word, so the owner's end-of-transaction strobe carries this name
    logic                                    owner_release;
    logic [mux4_rr_arbiter_pkg::NUM_REQ-1:0] grant;
    logic                                    address0;
    logic                                    address1;
    logic                                    valid;
    logic                                    timeout;

    modport master (
        output req, owner_release,
        input  grant, address0, address1, valid, timeout
    );

    modport slave (
        input  req, owner_release,
        output grant, address0, address1, valid, timeout
    );

endinterface

// File: rtl/mux4_rr_arbiter_rr_priority_pick.sv
// rtl/mux4_rr_arbiter_rr_priority_pick.sv - round-robin pick: rotate past last owner, priority-encode, un-rotate
module rr_priority_pick
    import mux4_rr_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   last,
    output logic [SEL_W-1:0]   idx,
    output logic               any
);

    logic [SEL_W-1:0]   base;
    logic [NUM_REQ-1:0] rot;
    logic [SEL_W-1:0]   off;

    assign base = last + SEL_W'(1);

    // rot[0] is the requester right after the last owner, so bit 0 has top priority
    always_comb begin
        rot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rot[i] = req[base + SEL_W'(i)];
        end
    end

    always_comb begin
        off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = SEL_W'(i);
            end
        end
    end

    assign idx = base + off;
    assign any = |req;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin owner arbiter driving the select lines of a shared 4:1 mux
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    mux4_rr_arbiter_if.slave  bus
);

    localparam bit               HOLD_LIMITED = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] LIMIT        = CNT_W'(HOLD_LIMITED ? MAX_HOLD - 1 : 0);

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic               timeout_q, timeout_d;

    logic [SEL_W-1:0]   pick_idx;
    logic               pick_any;
    logic               owner_req;
    logic               at_limit;

    rr_priority_pick u_pick (
        .req  (bus.req),
        .last (last_q),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    assign owner_req = bus.req[sel_q];
    assign at_limit  = HOLD_LIMITED && (cnt_q == LIMIT);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            sel_q     <= '0;
            last_q    <= SEL_W'(NUM_REQ - 1);
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_OWNED;
                    grant_d = onehot(pick_idx);
                    sel_d   = pick_idx;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            ST_OWNED: begin
                // select lines keep the old index through the idle gap so the mux can settle
                if (bus.owner_release || !owner_req || at_limit) begin
                    state_d   = ST_IDLE;
                    grant_d   = '0;
                    valid_d   = 1'b0;
                    last_d    = sel_q;
                    timeout_d = at_limit && !bus.owner_release && owner_req;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.grant    = grant_q;
    assign bus.address0 = sel_q[0];
    assign bus.address1 = sel_q[1];
    assign bus.valid    = valid_q;
    assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - directed-vector bench for mux4_rr_arbiter with hold limit 4
module tb_mux4_rr_arbiter;

    logic clk;
    logic reset_n;
    int   vectors;
    int   miscompares;

    mux4_rr_arbiter_if bus ();

    mux4_rr_arbiter #(
        .MAX_HOLD (4),
        .CNT_W    (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // observed word: {timeout, valid, address1, address0, grant}
    logic [7:0] obs;
    assign obs = {bus.timeout, bus.valid, bus.address1, bus.address0, bus.grant};

    function automatic logic [7:0] expv(input logic [3:0] g, input logic [1:0] a, input logic t);
        return {t, |g, a, g};
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got t/v/addr/grant=%b_%b_%b_%b expected %b_%b_%b_%b",
                     tag, got[7], got[6], got[5:4], got[3:0], exp[7], exp[6], exp[5:4], exp[3:0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] rot_g [8];
    logic [1:0] rot_a [8];

    initial begin
        vectors     = 0;
        miscompares = 0;
        rot_g = '{4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
        rot_a = '{2'd0,    2'd1,    2'd1,    2'd2,    2'd2,    2'd3,    2'd3,    2'd0};

        // reset held with all requesting
        reset_n           = 1'b0;
        bus.req           = 4'b1111;
        bus.owner_release = 1'b0;
        tick();
        check("reset_c1", obs, expv(4'b0000, 2'd0, 1'b0));
        tick();
        tick();
        check("reset_c3", obs, expv(4'b0000, 2'd0, 1'b0));
        reset_n = 1'b1;
        tick();
        check("first_grant", obs, expv(4'b0001, 2'd0, 1'b0));

        // rotation with release every owned cycle
        bus.owner_release = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("rotate_%0d", i), obs, expv(rot_g[i], rot_a[i], 1'b0));
        end

        // owner 0 -> owner 1, then owner 1 releases with only req0 up: wraps to 0
        tick();
        check("wrap_idle0", obs, expv(4'b0000, 2'd0, 1'b0));
        tick();
        check("wrap_own1", obs, expv(4'b0010, 2'd1, 1'b0));
        bus.req = 4'b0001;
        tick();
        check("wrap_rel1", obs, expv(4'b0000, 2'd1, 1'b0));
        tick();
        check("wrap_to0", obs, expv(4'b0001, 2'd0, 1'b0));

        // owner 3 releases with req 1001: owner 0 next
        bus.req = 4'b1000;
        tick();
        check("skip_idle", obs, expv(4'b0000, 2'd0, 1'b0));
        tick();
        check("skip_own3", obs, expv(4'b1000, 2'd3, 1'b0));
        bus.req = 4'b1001;
        tick();
        check("skip_rel3", obs, expv(4'b0000, 2'd3, 1'b0));
        tick();
        check("skip_to0", obs, expv(4'b0001, 2'd0, 1'b0));

        // hold limit: owner 2 keeps the mux exactly 4 cycles
        bus.req = 4'b0100;
        tick();
        check("to_idle", obs, expv(4'b0000, 2'd0, 1'b0));
        bus.owner_release = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("to_hold_%0d", i), obs, expv(4'b0100, 2'd2, 1'b0));
        end
        tick();
        check("to_pulse", obs, expv(4'b0000, 2'd2, 1'b1));
        tick();
        check("to_regrant", obs, expv(4'b0100, 2'd2, 1'b0));

        // release in the limit cycle: no timeout
        tick();
        tick();
        tick();
        check("co_hold4", obs, expv(4'b0100, 2'd2, 1'b0));
        bus.owner_release = 1'b1;
        tick();
        check("co_rel_limit", obs, expv(4'b0000, 2'd2, 1'b0));
        bus.owner_release = 1'b0;
        tick();
        check("co_regrant", obs, expv(4'b0100, 2'd2, 1'b0));
        tick();
        bus.req = 4'b0000;
        tick();
        check("co_req_drop", obs, expv(4'b0000, 2'd2, 1'b0));
        tick();
        check("co_idle_hold", obs, expv(4'b0000, 2'd2, 1'b0));

        // non-owner requests ignored, then reset mid-ownership
        bus.req = 4'b0100;
        tick();
        check("rs_own2", obs, expv(4'b0100, 2'd2, 1'b0));
        bus.req = 4'b1111;
        tick();
        check("rs_ignore", obs, expv(4'b0100, 2'd2, 1'b0));
        reset_n = 1'b0;
        tick();
        check("rs_abort", obs, expv(4'b0000, 2'd0, 1'b0));
        reset_n = 1'b1;
        bus.req = 4'b1010;
        tick();
        check("rs_ptr3", obs, expv(4'b0010, 2'd1, 1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
